// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer controller: FSM encoding,
// STATUS bit positions, parameter defaults and the STATUS packer.
package spi_pkg;

    localparam int unsigned CLK_DIV_DEF = 4;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned STATUS_W    = 8;

    // STATUS bit positions
    localparam int unsigned STS_BUSY     = 0;
    localparam int unsigned STS_OVR      = 1;
    localparam int unsigned STS_RX_FULL  = 2;
    localparam int unsigned STS_COLL     = 3;
    localparam int unsigned STS_TX_EMPTY = 4;
    localparam int unsigned STS_TX_READY = 5;
    localparam int unsigned STS_RX_NE    = 6;
    localparam int unsigned STS_ZERO     = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_LOW  = 3'd2,
        ST_HIGH = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Assemble the STATUS byte; ready/not-empty mirror empty/full and bit 7 is always zero
    function automatic logic [STATUS_W-1:0] pack_status(
        input logic busy,
        input logic ovr,
        input logic rx_full,
        input logic coll,
        input logic tx_empty
    );
        logic [STATUS_W-1:0] s;
        s               = '0;
        s[STS_BUSY]     = busy;
        s[STS_OVR]      = ovr;
        s[STS_RX_FULL]  = rx_full;
        s[STS_COLL]     = coll;
        s[STS_TX_EMPTY] = tx_empty;
        s[STS_TX_READY] = tx_empty;
        s[STS_RX_NE]    = rx_full;
        s[STS_ZERO]     = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: one-cycle tick every CLK_DIV enabled cycles,
// counter held at zero while disabled so each enable starts a fresh period.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick_c = en && (cnt == CNT_W'(CLK_DIV - 1));

    // Half-period counter; cleared when idle or on the terminal count
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (!en || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master with single TX/RX holding registers and sticky error flags.
// SCLK/MOSI/STATUS follow the FSM state on the same edge; SS_N trails the
// state by one cycle so it drops the cycle after LOAD and rises one cycle into IDLE.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic                S_CLK,
    input  logic                CLR,
    input  logic                SENDER_WRITE,
    input  logic [DATA_W-1:0]   DIN,
    input  logic                RECEIVER_READ,
    input  logic                ERR_CLR,
    input  logic                MISO,
    output logic [DATA_W-1:0]   DOUT,
    output logic                SCLK,
    output logic                MOSI,
    output logic                SS_N,
    output logic [STATUS_W-1:0] STATUS
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_W + 1);

    state_t               state;
    state_t               state_n;

    logic [DATA_W-1:0]    tx_hold;
    logic [DATA_W-1:0]    tx_hold_n;
    logic                 tx_full;
    logic                 tx_full_n;
    logic [DATA_W-1:0]    shift;
    logic [DATA_W-1:0]    shift_n;
    logic [DATA_W-1:0]    shifted;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt_n;
    logic                 miso_smp;
    logic                 miso_smp_n;
    logic                 rx_full;
    logic                 rx_full_n;
    logic                 ovr;
    logic                 ovr_n;
    logic                 coll;
    logic                 coll_n;
    logic                 ovr_set;
    logic                 coll_set;
    logic [DATA_W-1:0]    dout_n;
    logic                 sclk_n;
    logic                 mosi_n;
    logic                 ss_n_n;
    logic [STATUS_W-1:0]  status_n;
    logic                 div_en;
    logic                 tick_c;

    // Divider runs only while SCLK phases are being timed
    assign div_en  = (state == ST_LOW) || (state == ST_HIGH);
    assign shifted = {shift[DATA_W-2:0], miso_smp};

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (S_CLK),
        .clr    (CLR),
        .en     (div_en),
        .tick_c (tick_c)
    );

    // State register
    always_ff @(posedge S_CLK) begin
        if (CLR) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, host-side buffering and next output values
    always_comb begin
        state_n    = state;
        tx_hold_n  = tx_hold;
        tx_full_n  = tx_full;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        miso_smp_n = miso_smp;
        rx_full_n  = rx_full;
        dout_n     = DOUT;
        sclk_n     = SCLK;
        mosi_n     = MOSI;
        ovr_set    = 1'b0;
        coll_set   = 1'b0;

        // Host write is judged against the registered full flag only
        if (SENDER_WRITE) begin
            if (tx_full) begin
                coll_set = 1'b1;
            end else begin
                tx_hold_n = DIN;
                tx_full_n = 1'b1;
            end
        end

        // Host read pops the RX holding register; DONE may refill it below
        if (RECEIVER_READ && rx_full) begin
            rx_full_n = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                sclk_n = 1'b0;
                if (tx_full) begin
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_n   = tx_hold;
                tx_full_n = 1'b0;
                mosi_n    = tx_hold[DATA_W-1];
                bit_cnt_n = '0;
                sclk_n    = 1'b0;
                state_n   = ST_LOW;
            end
            ST_LOW: begin
                if (tick_c) begin
                    sclk_n     = 1'b1;
                    miso_smp_n = MISO;
                    state_n    = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tick_c) begin
                    sclk_n    = 1'b0;
                    shift_n   = shifted;
                    bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt_n < BIT_CNT_W'(DATA_W)) begin
                        mosi_n  = shifted[DATA_W-1];
                        state_n = ST_LOW;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (rx_full && !RECEIVER_READ) begin
                    ovr_set = 1'b1;
                end else begin
                    dout_n    = shift;
                    rx_full_n = 1'b1;
                end
                state_n = tx_full ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Sticky errors: a new event beats a simultaneous clear
        ovr_n  = ovr_set  | (ovr  & ~ERR_CLR);
        coll_n = coll_set | (coll & ~ERR_CLR);

        ss_n_n   = (state == ST_IDLE);
        status_n = pack_status(state_n != ST_IDLE, ovr_n, rx_full_n, coll_n, ~tx_full_n);
    end

    // Datapath and registered outputs
    always_ff @(posedge S_CLK) begin
        if (CLR) begin
            tx_hold  <= '0;
            tx_full  <= 1'b0;
            shift    <= '0;
            bit_cnt  <= '0;
            miso_smp <= 1'b0;
            rx_full  <= 1'b0;
            ovr      <= 1'b0;
            coll     <= 1'b0;
            DOUT     <= '0;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            SS_N     <= 1'b1;
            STATUS   <= pack_status(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end else begin
            tx_hold  <= tx_hold_n;
            tx_full  <= tx_full_n;
            shift    <= shift_n;
            bit_cnt  <= bit_cnt_n;
            miso_smp <= miso_smp_n;
            rx_full  <= rx_full_n;
            ovr      <= ovr_n;
            coll     <= coll_n;
            DOUT     <= dout_n;
            SCLK     <= sclk_n;
            MOSI     <= mosi_n;
            SS_N     <= ss_n_n;
            STATUS   <= status_n;
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl (CLK_DIV=2, DATA_W=8).
// A monitor rebuilds every MOSI byte at SCLK rises and scores it against
// a queue of bytes pushed when the write was issued.
module tb_spi_xfer_ctrl;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned DATA_W  = 8;

    logic              S_CLK = 1'b0;
    logic              CLR = 1'b1;
    logic              SENDER_WRITE = 1'b0;
    logic [DATA_W-1:0] DIN = '0;
    logic              RECEIVER_READ = 1'b0;
    logic              ERR_CLR = 1'b0;
    logic              MISO;
    logic [DATA_W-1:0] DOUT;
    logic              SCLK;
    logic              MOSI;
    logic              SS_N;
    logic [7:0]        STATUS;

    logic              loop_en = 1'b1;
    logic [7:0]        miso_pat = 8'h00;

    int                n_checks = 0;
    int                n_errors = 0;

    int                bit_idx = 0;
    logic [7:0]        mosi_acc = 8'h00;
    logic              sclk_q = 1'b0;
    logic [7:0]        exp_q[$];

    typedef struct {
        logic [7:0] din;
        logic [7:0] pat;
        logic [7:0] exp_dout;
        logic [7:0] exp_st;
    } vec_t;

    vec_t vecs[4];

    spi_xfer_ctrl #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) dut (
        .S_CLK         (S_CLK),
        .CLR           (CLR),
        .SENDER_WRITE  (SENDER_WRITE),
        .DIN           (DIN),
        .RECEIVER_READ (RECEIVER_READ),
        .ERR_CLR       (ERR_CLR),
        .MISO          (MISO),
        .DOUT          (DOUT),
        .SCLK          (SCLK),
        .MOSI          (MOSI),
        .SS_N          (SS_N),
        .STATUS        (STATUS)
    );

    always #5 S_CLK = ~S_CLK;

    // Slave model: echo MOSI, or play a pattern MSB first
    assign MISO = loop_en ? MOSI : miso_pat[3'(7 - bit_idx)];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // MOSI monitor and scoreboard
    always @(posedge S_CLK) begin
        if (CLR) begin
            bit_idx = 0;
            sclk_q  = 1'b0;
            exp_q.delete();
        end else begin
            #1;
            if (SCLK && !sclk_q) begin
                mosi_acc = {mosi_acc[6:0], MOSI};
                bit_idx++;
                if (bit_idx == 8) begin
                    bit_idx = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_unexpected: got %0h expected no transfer", mosi_acc);
                    end else begin
                        check("sb_mosi_byte", 32'(mosi_acc), 32'(exp_q.pop_front()));
                    end
                end
            end
            sclk_q = SCLK;
        end
    end

    task automatic write_byte(input logic [7:0] d, input bit expect_xfer);
        @(negedge S_CLK);
        SENDER_WRITE = 1'b1;
        DIN          = d;
        if (expect_xfer) exp_q.push_back(d);
        @(negedge S_CLK);
        SENDER_WRITE = 1'b0;
    endtask

    task automatic pulse_read();
        @(negedge S_CLK);
        RECEIVER_READ = 1'b1;
        @(negedge S_CLK);
        RECEIVER_READ = 1'b0;
    endtask

    task automatic pulse_errclr();
        @(negedge S_CLK);
        ERR_CLR = 1'b1;
        @(negedge S_CLK);
        ERR_CLR = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge S_CLK);
            #1;
            if (!STATUS[0] && SS_N) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_txe(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge S_CLK);
            #1;
            if (STATUS[4]) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  t_ss;
        int  t_sclk;
        int  n_busy;
        int  gap;
        int  falls;
        int  rises;
        bit  done;
        bit  prev;

        vecs[0] = '{din: 8'h5A, pat: 8'hC3, exp_dout: 8'hC3, exp_st: 8'h74};
        vecs[1] = '{din: 8'hFF, pat: 8'h00, exp_dout: 8'h00, exp_st: 8'h74};
        vecs[2] = '{din: 8'h00, pat: 8'hFF, exp_dout: 8'hFF, exp_st: 8'h74};
        vecs[3] = '{din: 8'h81, pat: 8'h7E, exp_dout: 8'h7E, exp_st: 8'h74};

        // Reset state
        repeat (3) @(posedge S_CLK);
        #1;
        check("rst_status", 32'(STATUS), 32'h30);
        check("rst_ss_n",   32'(SS_N),   32'd1);
        check("rst_sclk",   32'(SCLK),   32'd0);
        check("rst_mosi",   32'(MOSI),   32'd0);
        check("rst_dout",   32'(DOUT),   32'h00);
        @(negedge S_CLK);
        CLR = 1'b0;

        // Loopback A5 with latency and occupancy measurement
        loop_en = 1'b1;
        write_byte(8'hA5, 1'b1);
        t_ss = -1; t_sclk = -1; n_busy = 0; done = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge S_CLK);
            #1;
            if (t_ss < 0 && !SS_N) t_ss = k;
            if (t_sclk < 0 && SCLK) t_sclk = k;
            if (STATUS[0]) n_busy++;
            else if (n_busy > 0) begin
                done = 1'b1;
                break;
            end
        end
        check("a5_done",       32'(done),   32'd1);
        check("a5_ss_latency", 32'(t_ss),   32'd2);
        check("a5_sclk_rise",  32'(t_sclk), 32'(2 + CLK_DIV));
        check("a5_busy_cyc",   32'(n_busy), 32'(2 * CLK_DIV * DATA_W + 2));
        check("a5_status",     32'(STATUS), 32'h74);
        check("a5_dout",       32'(DOUT),   32'hA5);
        @(posedge S_CLK);
        #1;
        check("a5_ss_release", 32'(SS_N),   32'd1);
        pulse_read();
        check("a5_after_read", 32'(STATUS), 32'h30);

        // Table of single transfers against a patterned slave
        loop_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            miso_pat = vecs[i].pat;
            write_byte(vecs[i].din, 1'b1);
            wait_idle("vec_idle");
            check("vec_dout",   32'(DOUT),   32'(vecs[i].exp_dout));
            check("vec_status", 32'(STATUS), 32'(vecs[i].exp_st));
            pulse_read();
            check("vec_popped", 32'(STATUS), 32'h30);
        end

        // Read while empty changes nothing
        pulse_read();
        check("rd_empty_status", 32'(STATUS), 32'h30);
        check("rd_empty_dout",   32'(DOUT),   32'h7E);

        // Back-to-back transfers: SS_N never rises in between, second byte overruns
        loop_en = 1'b1;
        write_byte(8'h3C, 1'b1);
        wait_txe("b2b_txe");
        write_byte(8'hC3, 1'b1);
        gap = 0; done = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge S_CLK);
            #1;
            if (STATUS[0] && SS_N) gap++;
            if (!STATUS[0]) begin
                done = 1'b1;
                break;
            end
        end
        check("b2b_done",    32'(done),   32'd1);
        check("b2b_ss_gap",  32'(gap),    32'd0);
        check("b2b_no_coll", 32'(STATUS[3]), 32'd0);
        check("b2b_status",  32'(STATUS), 32'h76);
        check("b2b_dout",    32'(DOUT),   32'h3C);
        pulse_errclr();
        check("b2b_errclr",  32'(STATUS), 32'h74);
        pulse_read();
        check("b2b_popped",  32'(STATUS), 32'h30);

        // Collisions: write during LOAD with ERR_CLR, and write with both registers busy
        @(negedge S_CLK);
        SENDER_WRITE = 1'b1; DIN = 8'h44; exp_q.push_back(8'h44);
        @(negedge S_CLK);
        SENDER_WRITE = 1'b0;
        @(negedge S_CLK);
        SENDER_WRITE = 1'b1; DIN = 8'h55; ERR_CLR = 1'b1;
        @(negedge S_CLK);
        SENDER_WRITE = 1'b0; ERR_CLR = 1'b0;
        check("coll_in_load", 32'(STATUS[3]), 32'd1);
        pulse_errclr();
        check("coll_clr1", 32'(STATUS[3]), 32'd0);
        write_byte(8'h22, 1'b1);
        write_byte(8'h33, 1'b0);
        check("coll_both_full", 32'(STATUS[3]), 32'd1);
        pulse_errclr();
        check("coll_clr2", 32'(STATUS[3]), 32'd0);
        wait_idle("coll_idle");
        check("coll_dout",   32'(DOUT),   32'h44);
        check("coll_status", 32'(STATUS), 32'h76);
        pulse_errclr();
        pulse_read();
        check("coll_popped", 32'(STATUS), 32'h30);

        // Read coinciding with the second DONE: no overrun, new byte kept
        write_byte(8'h66, 1'b1);
        falls = 0; prev = 1'b0; done = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge S_CLK);
            #1;
            if (k == 3) begin
                SENDER_WRITE = 1'b1; DIN = 8'h77; exp_q.push_back(8'h77);
            end
            if (k == 4) SENDER_WRITE = 1'b0;
            if (prev && !SCLK) falls++;
            prev = SCLK;
            if (falls == 16 && !done) begin
                RECEIVER_READ = 1'b1;
                done = 1'b1;
            end else begin
                RECEIVER_READ = 1'b0;
                if (done) break;
            end
        end
        check("rdd_reached", 32'(done), 32'd1);
        wait_idle("rdd_idle");
        check("rdd_status", 32'(STATUS), 32'h74);
        check("rdd_dout",   32'(DOUT),   32'h77);
        pulse_read();

        // Reset mid-transfer at the fourth SCLK rise, then a clean transfer
        write_byte(8'h99, 1'b1);
        rises = 0; prev = 1'b0; done = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge S_CLK);
            #1;
            if (SCLK && !prev) rises++;
            prev = SCLK;
            if (rises == 4) begin
                CLR  = 1'b1;
                done = 1'b1;
                break;
            end
        end
        check("clr_reached", 32'(done), 32'd1);
        @(posedge S_CLK);
        #1;
        CLR = 1'b0;
        check("clr_ss_n",   32'(SS_N),   32'd1);
        check("clr_sclk",   32'(SCLK),   32'd0);
        check("clr_status", 32'(STATUS), 32'h30);
        check("clr_dout",   32'(DOUT),   32'h00);
        check("clr_mosi",   32'(MOSI),   32'd0);
        write_byte(8'h5A, 1'b1);
        wait_idle("post_clr_idle");
        check("post_clr_dout",   32'(DOUT),   32'h5A);
        check("post_clr_status", 32'(STATUS), 32'h74);

        repeat (5) @(posedge S_CLK);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
